apb4_slave_mem: RTL and testbench

- Parametrised APB4 completer: a byte-addressable word memory with programmable wait states, PSTRB byte-lane writes and PSLVERR error reporting.
- Connects to the slave side of the APB bus interface. Serves as the DUT-side target for APB master agents, and as a reusable register/memory backing store.
- Generalises the fixed 32-bit APB3 signal set to configurable data, address and depth, and adds wait-state and error behaviour.

---
 rtl/apb4_slave_pkg.sv | 21 ++
 rtl/apb4_slave_mem_array.sv | 42 ++++
 rtl/apb4_slave_mem.sv | 131 +++++++++++++
 tb/tb_apb4_slave_mem.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/apb4_slave_pkg.sv
// Shared types and helpers for the APB4 memory completer.
// Holds the FSM state type, the wait-counter width and the lane/offset helpers.
package apb4_slave_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int WAIT_CNT_W = 4;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

  // An 8-bit bus has no byte-offset bits at all.
  function automatic int off_width(input int dw);
    return (dw <= 8) ? 0 : $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/apb4_slave_mem_array.sv
// DEPTH x DATA_WIDTH storage: per-byte-lane synchronous write, combinational read,
// asynchronous clear of every word.
module apb4_slave_mem_array
  import apb4_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = 8
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [IDX_W-1:0]        i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int LANES = lane_count(DATA_WIDTH);
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Out-of-range indices can only arise for non-power-of-two depths.
  assign o_rdata = ({1'b0, i_raddr} < DEPTH_L) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/apb4_slave_mem.sv
// APB4 completer backed by a byte-lane word memory with wait states and PSLVERR.
// Optional build macro APB4_SLAVE_MEM_PROT_EN guards the lowest DEPTH/4 words by pprot[0].
module apb4_slave_mem
  import apb4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int OFF_W = off_width(DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0]            DEPTH_L = (IDX_W+1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0]     WAIT_L  = WAIT_CNT_W'(WAIT_CYCLES);

  apb_state_e              r_state;
  logic [WAIT_CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_write;
  logic [DATA_WIDTH/8-1:0] r_strb;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_misalign;
  logic                  w_idx_oob;
  logic                  w_rd_strb;
  logic                  w_prot_err;
  logic                  w_err;
  logic                  w_ready;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_mem_rdata;
  logic                  w_unused;

  assign w_idx = IDX_W'(paddr >> OFF_W);

  if (OFF_W > 0) begin : g_off
    assign w_misalign = |paddr[OFF_W-1:0];
  end else begin : g_no_off
    assign w_misalign = 1'b0;
  end

  assign w_idx_oob = ({1'b0, w_idx} >= DEPTH_L);
  assign w_rd_strb = !pwrite && (pstrb != '0);

`ifdef APB4_SLAVE_MEM_PROT_EN
  localparam logic [IDX_W:0] PRIV_L = (IDX_W+1)'(DEPTH / 4);
  assign w_prot_err = ({1'b0, w_idx} < PRIV_L) && !pprot[0];
`else
  assign w_prot_err = 1'b0;
`endif

  assign w_err = w_misalign | w_idx_oob | w_rd_strb | w_prot_err;

  // Upper address bits and unused pprot bits are intentionally ignored.
  assign w_unused = ^{paddr, pprot};

  // Completion is decoded purely from registered state.
  assign w_ready = (r_state == ACCESS) && (r_cnt == '0);
  assign w_we    = w_ready && psel && penable && r_write && !r_err;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_strb  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (psel && !penable) begin
            r_state <= ACCESS;
            r_cnt   <= WAIT_L;
            r_idx   <= w_idx;
            r_write <= pwrite;
            r_strb  <= pstrb;
            r_err   <= w_err;
            r_rdata <= (!pwrite && !w_err) ? w_mem_rdata : '0;
          end
        end
        ACCESS: begin
          if (!psel) begin
            r_state <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (penable) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  apb4_slave_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .pclk   (pclk),
    .prst   (prst),
    .i_we   (w_we),
    .i_waddr(r_idx),
    .i_wdata(pwdata),
    .i_wstrb(r_strb),
    .i_raddr(w_idx),
    .o_rdata(w_mem_rdata)
  );

  assign pready  = w_ready;
  assign pslverr = w_ready && r_err;
  assign prdata  = (w_ready && !r_write) ? r_rdata : '0;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Scoreboard bench for apb4_slave_mem: one zero-wait and one three-wait instance
// share the bus; the driver queues expected responses, the monitor checks completions.
module tb_apb4_slave_mem;

  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;
  int          sel_dut = 0;

  logic        psel0, psel1;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [31:0] cur_prdata;
  logic        cur_pready, cur_pslverr;

  // {latency[7:0], pslverr, prdata[31:0]}
  logic [40:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  assign psel0 = psel && (sel_dut == 0);
  assign psel1 = psel && (sel_dut == 1);
  assign cur_prdata  = (sel_dut == 0) ? prdata0  : prdata1;
  assign cur_pready  = (sel_dut == 0) ? pready0  : pready1;
  assign cur_pslverr = (sel_dut == 0) ? pslverr0 : pslverr1;

  apb4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .prst(prst), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(3)) u_dut1 (
    .pclk(pclk), .prst(prst), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
  );

  // Clock / reset
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Driver: one complete transfer, expectation queued at setup
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                      input logic [31:0] exp_rd, input logic exp_err);
    int  lat;
    logic done;
    lat = (d == 0) ? 2 : 5;
    sel_dut = d;
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
    exp_q.push_back({8'(lat), exp_err, exp_rd});
    @(posedge pclk); #1;
    penable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      if (cur_pready) done = 1'b1;
    end
    check("xfer_done", {31'b0, done}, 32'd1);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Driver: write on the wait-state instance, psel dropped mid-wait
  task automatic abort_write(input logic [31:0] addr, input logic [31:0] wdata);
    sel_dut = 1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = addr; pwdata = wdata; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  // Driver: reset asserted during the access phase of a write
  task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] wdata);
    sel_dut = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = addr; pwdata = wdata; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 prst = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    prst = 1'b1;
    @(posedge pclk); #1;
  endtask

  // Monitor / scoreboard
  always @(negedge pclk) begin
    logic [40:0] e;
    if (prst) begin
      if (psel && !penable) cyc = 1;
      else if (psel && penable) cyc = cyc + 1;
      if (cur_pready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("prdata", cur_prdata, e[31:0]);
          check("pslverr", {31'b0, cur_pslverr}, {31'b0, e[32]});
          check("latency", 32'(cyc), {24'b0, e[40:33]});
        end
      end else begin
        check("idle_outputs", {cur_prdata[30:0], cur_pslverr}, 32'd0);
      end
    end
  end

  localparam logic [2:0] P = 3'b001;

  initial begin
    prst = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_prdata0", prdata0, 32'd0);
    check("rst_pready0", {31'b0, pready0}, 32'd0);
    check("rst_pslverr0", {31'b0, pslverr0}, 32'd0);
    check("rst_prdata1", prdata1, 32'd0);
    check("rst_pready1", {31'b0, pready1}, 32'd0);
    check("rst_pslverr1", {31'b0, pslverr1}, 32'd0);
    prst = 1'b1;
    @(posedge pclk); #1;

    // Zero-wait instance: full write, read-back, lane writes
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, P, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, P, 32'hDEADBEEF, 1'b0);
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, P, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, P, 32'h00BB00DD, 1'b0);
    // Errors: misaligned write, read with strobes, misaligned read
    xfer(0, 1'b1, 32'h13, 32'h12345678, 4'hF, P, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h1, P, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h12, 32'h0, 4'h0, P, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, P, 32'hDEADBEEF, 1'b0);
    // Zero-strobe write is a legal no-op; high address bits alias
    xfer(0, 1'b1, 32'h10, 32'h55555555, 4'h0, P, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h410, 32'h0, 4'h0, P, 32'hDEADBEEF, 1'b0);
    // Last word
    xfer(0, 1'b1, 32'h3FC, 32'h0F0F0F0F, 4'hF, P, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h3FC, 32'h0, 4'h0, P, 32'h0F0F0F0F, 1'b0);

    // Three-wait instance: latency, abort, write/read
    xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, P, 32'h0, 1'b0);
    abort_write(32'h08, 32'h11223344);
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, P, 32'h0, 1'b0);
    xfer(1, 1'b1, 32'h08, 32'hA5A5A5A5, 4'b1100, P, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, P, 32'hA5A50000, 1'b0);

`ifdef APB4_SLAVE_MEM_PROT_EN
    xfer(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b001, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 3'b001, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b001, 32'hCAFEF00D, 1'b0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h100, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);
`else
    xfer(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 32'hCAFEF00D, 1'b0);
`endif

    // Reset mid-transfer clears memory and drops the pending write
    reset_mid_write(32'h30, 32'h77777777);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, P, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, P, 32'h0, 1'b0);

    repeat (3) @(posedge pclk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
